// File: rtl/tone_pwm_pkg.sv
// Shared definitions for the multi-channel tone/PWM generator.
//   - Default channel count, counter width and channel-select width.
//   - duty_50(): duty value giving a 50% square tone for a given period,
//     i.e. (P+1)>>1, computed one bit wider so P = all-ones cannot overflow.
package tone_pwm_pkg;

    localparam int NCH_DEF   = 4;
    localparam int CNT_W_DEF = 20;
    localparam int CH_W_DEF  = 2;

    function automatic logic [CNT_W_DEF-1:0] duty_50(input logic [CNT_W_DEF-1:0] period);
        logic [CNT_W_DEF:0] cycle_len;
        cycle_len = {1'b0, period} + (CNT_W_DEF + 1)'(1);
        return cycle_len[CNT_W_DEF:1];
    endfunction

endpackage

// File: rtl/tone_pwm_chan.sv
// One tone/PWM channel.
//   clk        system clock, rising edge
//   rst_n      synchronous reset, active-low
//   en         run enable
//   ld         write strobe for this channel (one cycle per write)
//   ld_period  new period P (cycle length P+1 clk)
//   ld_duty    new duty D (high for D clk per cycle)
//   pwm        registered PWM output
//   tick       registered 1-clk pulse on counter wrap
// New period/duty values land in a shadow pair and are copied to the active
// pair only at a wrap (or right away while the channel is stopped), so a
// period already in progress is never altered.
module tone_pwm_chan
    import tone_pwm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             ld,
    input  logic [CNT_W-1:0] ld_period,
    input  logic [CNT_W-1:0] ld_duty,
    output logic             pwm,
    output logic             tick
);

    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic [CNT_W-1:0] act_period_q, act_period_d;
    logic [CNT_W-1:0] act_duty_q,   act_duty_d;
    logic [CNT_W-1:0] shd_period_q, shd_period_d;
    logic [CNT_W-1:0] shd_duty_q,   shd_duty_d;
    logic             pend_q,       pend_d;
    logic             pwm_q,        pwm_d;
    logic             tick_q,       tick_d;

    always_comb begin
        cnt_d        = cnt_q;
        act_period_d = act_period_q;
        act_duty_d   = act_duty_q;
        shd_period_d = shd_period_q;
        shd_duty_d   = shd_duty_q;
        pend_d       = pend_q;
        pwm_d        = 1'b0;
        tick_d       = 1'b0;

        // A later write simply overwrites the shadow: last write wins.
        if (ld) begin
            shd_period_d = ld_period;
            shd_duty_d   = ld_duty;
            pend_d       = 1'b1;
        end

        if (en) begin
            // Unsigned compare makes D > P read as "always high" with no wrap.
            pwm_d = (cnt_q < act_duty_q);
            if (cnt_q == act_period_q) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                if (ld) begin
                    // Write on the wrap cycle goes straight to the active pair.
                    act_period_d = ld_period;
                    act_duty_d   = ld_duty;
                    pend_d       = 1'b0;
                end else if (pend_q) begin
                    act_period_d = shd_period_q;
                    act_duty_d   = shd_duty_q;
                    pend_d       = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = '0;
            // Stopped: no period to protect, so apply pending values now.
            // A write in this same cycle stays pending for the next one.
            if (pend_q) begin
                act_period_d = shd_period_q;
                act_duty_d   = shd_duty_q;
                pend_d       = ld;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            act_period_q <= '0;
            act_duty_q   <= '0;
            shd_period_q <= '0;
            shd_duty_q   <= '0;
            pend_q       <= 1'b0;
            pwm_q        <= 1'b0;
            tick_q       <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            act_period_q <= act_period_d;
            act_duty_q   <= act_duty_d;
            shd_period_q <= shd_period_d;
            shd_duty_q   <= shd_duty_d;
            pend_q       <= pend_d;
            pwm_q        <= pwm_d;
            tick_q       <= tick_d;
        end
    end

    assign pwm  = pwm_q;
    assign tick = tick_q;

endmodule

// File: rtl/tone_pwm_mc.sv
// Multi-channel tone/PWM generator.
//   clk          system clock, rising edge
//   rst_n        synchronous reset, active-low
//   ch_en        per-channel run enable           [NCH]
//   wr_en        write strobe, one cycle per write
//   wr_ch        target channel of the write      [CH_W]
//   wr_period    new period P (cycle = P+1 clk)   [CNT_W]
//   wr_duty      new duty D (high D clk)          [CNT_W]
//   pwm_out      registered PWM/tone outputs      [NCH]
//   period_tick  1-clk pulse on each channel wrap [NCH]
// The single write port is decoded to a per-channel load strobe; a channel
// select of NCH or above matches no channel and is dropped.
module tone_pwm_mc
    import tone_pwm_pkg::*;
#(
    parameter int NCH   = NCH_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int CH_W  = CH_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH-1:0]   ch_en,
    input  logic             wr_en,
    input  logic [CH_W-1:0]  wr_ch,
    input  logic [CNT_W-1:0] wr_period,
    input  logic [CNT_W-1:0] wr_duty,
    output logic [NCH-1:0]   pwm_out,
    output logic [NCH-1:0]   period_tick
);

    logic [NCH-1:0] ld_vec;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            assign ld_vec[gi] = wr_en & (wr_ch == CH_W'(gi));

            tone_pwm_chan #(
                .CNT_W (CNT_W)
            ) u_chan (
                .clk       (clk),
                .rst_n     (rst_n),
                .en        (ch_en[gi]),
                .ld        (ld_vec[gi]),
                .ld_period (wr_period),
                .ld_duty   (wr_duty),
                .pwm       (pwm_out[gi]),
                .tick      (period_tick[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_tone_pwm_mc.sv
// Bench for tone_pwm_mc (5 channels, 3-bit select so channel 5 is an
// invalid target). The driver issues directed writes/enables and, for each,
// pushes the hand-derived pin values expected after numbered clock edges
// into a scoreboard queue. A separate monitor samples on each falling edge
// and checks every entry due at the current edge number.
module tb_tone_pwm_mc;
    import tone_pwm_pkg::*;

    localparam int NCH   = 5;
    localparam int CH_W  = 3;
    localparam int CNT_W = 20;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NCH-1:0]   ch_en;
    logic             wr_en;
    logic [CH_W-1:0]  wr_ch;
    logic [CNT_W-1:0] wr_period;
    logic [CNT_W-1:0] wr_duty;
    logic [NCH-1:0]   pwm_out;
    logic [NCH-1:0]   period_tick;

    tone_pwm_mc #(.NCH(NCH), .CNT_W(CNT_W), .CH_W(CH_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ch_en       (ch_en),
        .wr_en       (wr_en),
        .wr_ch       (wr_ch),
        .wr_period   (wr_period),
        .wr_duty     (wr_duty),
        .pwm_out     (pwm_out),
        .period_tick (period_tick)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far; outputs read at a falling edge
    // are the ones produced by edge number edge_cnt.
    int edge_cnt = 0;
    always @(posedge clk) edge_cnt++;

    typedef struct {
        int edge_n;
        int ch;
        bit pwm;
        bit tick;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   done     = 1'b0;

    // Expected value of a running channel: k clocks after it started
    // (cnt=0) with period P and duty D, pwm = (k mod (P+1)) < D and the
    // tick fires when k mod (P+1) == P.
    task automatic exp_run(input int ch, input int base, input int p, input int d,
                           input int from_e, input int to_e);
        for (int n = from_e; n <= to_e; n++) begin
            int k;
            k = (n - base) % (p + 1);
            exp_q.push_back('{n, ch, (k < d), (k == p)});
        end
    endtask

    task automatic exp_const(input int ch, input int from_e, input int to_e,
                             input bit p_v, input bit t_v);
        for (int n = from_e; n <= to_e; n++)
            exp_q.push_back('{n, ch, p_v, t_v});
    endtask

    task automatic wait_until(input int n);
        while (edge_cnt < n) @(negedge clk);
    endtask

    // Single-cycle write, applied at the next rising edge.
    task automatic wr(input int ch, input int p, input int d);
        $display("write  edge=%0d ch=%0d P=%0d D=%0d", edge_cnt + 1, ch, p, d);
        wr_en     = 1'b1;
        wr_ch     = CH_W'(ch);
        wr_period = CNT_W'(p);
        wr_duty   = CNT_W'(d);
        @(negedge clk);
        wr_en     = 1'b0;
    endtask

    // Stop the channel, write new values, let them settle into the active
    // pair while stopped, then enable. s is the first running edge (cnt=0).
    task automatic cfg_start(input int ch, input int p, input int d, output int s);
        ch_en[ch] = 1'b0;
        wr(ch, p, d);
        @(negedge clk);
        ch_en[ch] = 1'b1;
        s = edge_cnt + 1;
    endtask

    // Monitor: check every scoreboard entry due at this edge.
    initial begin
        while (!done) begin
            @(negedge clk);
            for (int i = exp_q.size() - 1; i >= 0; i--) begin
                if (exp_q[i].edge_n == edge_cnt) begin
                    n_checks++;
                    if (pwm_out[exp_q[i].ch] !== exp_q[i].pwm ||
                        period_tick[exp_q[i].ch] !== exp_q[i].tick) begin
                        n_errors++;
                        $display("FAIL pin_check edge=%0d ch=%0d: got pwm=%b tick=%b, expected pwm=%b tick=%b",
                                 edge_cnt, exp_q[i].ch, pwm_out[exp_q[i].ch],
                                 period_tick[exp_q[i].ch], exp_q[i].pwm, exp_q[i].tick);
                    end
                    exp_q.delete(i);
                end else if (exp_q[i].edge_n < edge_cnt) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL missed_check edge=%0d ch=%0d: sampled at edge %0d, expected at edge %0d",
                             exp_q[i].edge_n, exp_q[i].ch, edge_cnt, exp_q[i].edge_n);
                    exp_q.delete(i);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit at edge %0d, required completion", edge_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, s1, s2, s3, sp, s5, s6, s7, r, t;

        // 1. Reset held 3 clk with a write and all enables active.
        rst_n     = 1'b0;
        ch_en     = '1;
        wr_en     = 1'b1;
        wr_ch     = '0;
        wr_period = CNT_W'(5);
        wr_duty   = CNT_W'(2);
        for (int c = 0; c < NCH; c++) exp_const(c, 1, 3, 1'b0, 1'b0);
        wait_until(3);
        rst_n = 1'b1;
        wr_en = 1'b0;
        ch_en = '0;
        for (int c = 0; c < NCH; c++) exp_const(c, 4, 6, 1'b0, 1'b0);
        wait_until(6);

        // 2. Basic PWM on ch0: P=9 D=3 -> high 3, low 7, tick every 10.
        cfg_start(0, 9, 3, s0);
        exp_run(0, s0, 9, 3, s0, s0 + 29);
        for (int c = 1; c < NCH; c++) exp_const(c, s0, s0 + 9, 1'b0, 1'b0);
        wait_until(s0 + 29);

        // 3. ch1 P=7 D=4, rewritten to P=3 D=1 mid-period.
        cfg_start(1, 7, 4, s1);
        exp_run(1, s1, 7, 4, s1, s1 + 7);
        exp_run(1, s1 + 8, 3, 1, s1 + 8, s1 + 19);
        wait_until(s1 + 2);
        wr(1, 3, 1);
        wait_until(s1 + 19);

        // 4a. Write to nonexistent channel: ch0 and ch1 keep their patterns.
        t = edge_cnt;
        exp_run(0, s0, 9, 3, t + 1, t + 25);
        exp_run(1, s1 + 8, 3, 1, t + 1, t + 25);
        wr(NCH, 1, 1);
        wait_until(t + 25);

        // 4b. D=0 -> never high; D>P -> always high; P=0 D=1 -> both every clk.
        cfg_start(2, 4, 0, s2);
        exp_run(2, s2, 4, 0, s2, s2 + 9);
        cfg_start(3, 5, 6, s3);
        exp_run(3, s3, 5, 6, s3, s3 + 11);
        wait_until(s3 + 11);
        cfg_start(2, 0, 1, sp);
        exp_const(2, sp, sp + 7, 1'b1, 1'b1);
        wait_until(sp + 7);

        // 5a. ch2 P=4 D=2 (50% tone); write on its wrap edge takes effect at once.
        cfg_start(2, 4, int'(duty_50(CNT_W_DEF'(4))), s5);
        exp_run(2, s5, 4, 2, s5, s5 + 4);
        exp_run(2, s5 + 5, 2, 1, s5 + 5, s5 + 13);
        wait_until(s5 + 3);
        wr(2, 2, 1);
        wait_until(s5 + 13);

        // 5b. Two writes to ch3 inside one period: only the second applies.
        cfg_start(3, 7, 2, s6);
        exp_run(3, s6, 7, 2, s6, s6 + 7);
        exp_run(3, s6 + 8, 5, 1, s6 + 8, s6 + 19);
        wait_until(s6);
        wr(3, 3, 3);
        wait_until(s6 + 2);
        wr(3, 5, 1);
        wait_until(s6 + 19);

        // 6a. Drop ch_en[3] at cnt=5, re-enable: restart from cnt=0.
        cfg_start(3, 9, 7, s7);
        exp_run(3, s7, 9, 7, s7, s7 + 4);
        exp_const(3, s7 + 5, s7 + 7, 1'b0, 1'b0);
        r = s7 + 8;
        exp_run(3, r, 9, 7, r, r + 11);
        wait_until(s7 + 4);
        ch_en[3] = 1'b0;
        wait_until(s7 + 7);
        ch_en[3] = 1'b1;
        wait_until(r + 12);

        // 6b. Reset mid-period: everything 0 next clk; afterwards ch3 runs
        // with cleared active values (P=0 D=0 -> tick every clk, pwm low).
        rst_n = 1'b0;
        for (int c = 0; c < NCH; c++) exp_const(c, r + 13, r + 13, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        ch_en = 5'b01000;
        for (int c = 0; c < NCH; c++)
            exp_const(c, r + 14, r + 17, 1'b0, (c == 3));
        wait_until(r + 17);

        repeat (2) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
